// File: rtl/mips_pkg.sv
// Shared definitions for the multicycle MIPS control path: opcodes, functs,
// ALU control codes, state encoding and the datapath control word.
package mips_pkg;

    localparam int unsigned OPCODE_W   = 6;
    localparam int unsigned FUNCT_W    = 6;
    localparam int unsigned ALU_CTRL_W = 4;
    localparam int unsigned STATE_W    = 4;
    localparam int unsigned WAIT_W     = 8;

    localparam logic [OPCODE_W-1:0] OP_RTYPE = 6'd0;
    localparam logic [OPCODE_W-1:0] OP_J     = 6'd2;
    localparam logic [OPCODE_W-1:0] OP_BEQ   = 6'd4;
    localparam logic [OPCODE_W-1:0] OP_ADDI  = 6'd8;
    localparam logic [OPCODE_W-1:0] OP_LW    = 6'd35;
    localparam logic [OPCODE_W-1:0] OP_SW    = 6'd43;

    localparam logic [FUNCT_W-1:0] FN_ADD = 6'd32;
    localparam logic [FUNCT_W-1:0] FN_SUB = 6'd34;
    localparam logic [FUNCT_W-1:0] FN_AND = 6'd36;
    localparam logic [FUNCT_W-1:0] FN_OR  = 6'd37;
    localparam logic [FUNCT_W-1:0] FN_SLT = 6'd42;

    localparam logic [ALU_CTRL_W-1:0] ALU_AND = 4'b0000;
    localparam logic [ALU_CTRL_W-1:0] ALU_OR  = 4'b0001;
    localparam logic [ALU_CTRL_W-1:0] ALU_ADD = 4'b0010;
    localparam logic [ALU_CTRL_W-1:0] ALU_SUB = 4'b0110;
    localparam logic [ALU_CTRL_W-1:0] ALU_SLT = 4'b0111;

    localparam logic [1:0] SRCB_B      = 2'd0;
    localparam logic [1:0] SRCB_FOUR   = 2'd1;
    localparam logic [1:0] SRCB_IMM    = 2'd2;
    localparam logic [1:0] SRCB_IMM_SH = 2'd3;

    localparam logic [1:0] PCSRC_ALU    = 2'd0;
    localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
    localparam logic [1:0] PCSRC_JUMP   = 2'd2;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE     = 4'd0,
        ST_FETCH    = 4'd1,
        ST_DECODE   = 4'd2,
        ST_MEM_ADDR = 4'd3,
        ST_MEM_RD   = 4'd4,
        ST_MEM_WB   = 4'd5,
        ST_MEM_WR   = 4'd6,
        ST_EXEC_R   = 4'd7,
        ST_R_WB     = 4'd8,
        ST_BRANCH   = 4'd9,
        ST_JUMP     = 4'd10,
        ST_ADDI_EX  = 4'd11,
        ST_ADDI_WB  = 4'd12,
        ST_HALT     = 4'd15
    } state_e;

    // Datapath control word produced each cycle by the main FSM.
    typedef struct packed {
        logic                  pc_write;
        logic                  pc_write_cond;
        logic                  i_or_d;
        logic                  mem_read;
        logic                  mem_write;
        logic                  ir_write;
        logic                  reg_dst;
        logic                  mem_to_reg;
        logic                  reg_write;
        logic                  alu_src_a;
        logic [1:0]            alu_src_b;
        logic [ALU_CTRL_W-1:0] alu_ctrl;
        logic [1:0]            pc_source;
        logic                  retire;
    } ctrl_t;

endpackage

// File: rtl/mips_multicycle_ctrl_if.sv
// Control/status bundle between the main control FSM and the multicycle datapath.
interface mips_multicycle_ctrl_if;
    import mips_pkg::*;

    logic [OPCODE_W-1:0]   opcode;
    logic [FUNCT_W-1:0]    funct;
    logic                  zero;
    logic                  mem_ready;

    logic                  pc_write;
    logic                  pc_write_cond;
    logic                  i_or_d;
    logic                  mem_read;
    logic                  mem_write;
    logic                  ir_write;
    logic                  reg_dst;
    logic                  mem_to_reg;
    logic                  reg_write;
    logic                  alu_src_a;
    logic [1:0]            alu_src_b;
    logic [ALU_CTRL_W-1:0] alu_ctrl;
    logic [1:0]            pc_source;
    logic                  retire;
    logic                  illegal_op;
    logic                  bus_error;
    logic [STATE_W-1:0]    state;

    modport master (
        input  opcode, funct, zero, mem_ready,
        output pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
               reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_ctrl,
               pc_source, retire, illegal_op, bus_error, state
    );

    modport slave (
        output opcode, funct, zero, mem_ready,
        input  pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
               reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_ctrl,
               pc_source, retire, illegal_op, bus_error, state
    );

endinterface

// File: rtl/mips_alu_decode.sv
// R-type funct to ALU control decode with a valid flag; purely combinational
// so a pipelined control unit can reuse it unchanged.
module mips_alu_decode
    import mips_pkg::*;
#(
    parameter bit ENABLE_SLT = 1'b1
) (
    input  logic [FUNCT_W-1:0]    funct,
    output logic [ALU_CTRL_W-1:0] alu_ctrl,
    output logic                  valid
);

    always_comb begin
        alu_ctrl = ALU_AND;
        valid    = 1'b0;
        case (funct)
            FN_ADD: begin alu_ctrl = ALU_ADD; valid = 1'b1; end
            FN_SUB: begin alu_ctrl = ALU_SUB; valid = 1'b1; end
            FN_AND: begin alu_ctrl = ALU_AND; valid = 1'b1; end
            FN_OR:  begin alu_ctrl = ALU_OR;  valid = 1'b1; end
            FN_SLT: begin
                if (ENABLE_SLT) begin
                    alu_ctrl = ALU_SLT;
                    valid    = 1'b1;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Main control FSM of the multicycle MIPS: sequences fetch/decode/execute/
// memory/writeback, bounds memory wait states and traps illegal instructions.
module mips_multicycle_ctrl
    import mips_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter bit          ENABLE_SLT  = 1'b1
) (
    input  logic                   clock,
    input  logic                   reset_n,
    mips_multicycle_ctrl_if.master ctl
);

    state_e              state_q, state_d;
    logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic                illegal_q, illegal_d;
    logic                bus_err_q, bus_err_d;
    ctrl_t               ctrl_c;
    logic [ALU_CTRL_W-1:0] dec_alu_ctrl;
    logic                dec_valid;
    logic                wait_limit_c;

    mips_alu_decode #(.ENABLE_SLT(ENABLE_SLT)) u_alu_decode (
        .funct    (ctl.funct),
        .alu_ctrl (dec_alu_ctrl),
        .valid    (dec_valid)
    );

    // This wait cycle is the last one allowed if mem_ready stays low.
    assign wait_limit_c = ((wait_cnt_q + WAIT_W'(1)) == WAIT_W'(MEM_TIMEOUT));

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = '0;
        illegal_d  = illegal_q;
        bus_err_d  = bus_err_q;
        ctrl_c     = '0;

        unique case (state_q)
            ST_IDLE: state_d = ST_FETCH;
            ST_FETCH: begin
                ctrl_c.mem_read  = 1'b1;
                ctrl_c.alu_src_b = SRCB_FOUR;
                ctrl_c.alu_ctrl  = ALU_ADD;
                ctrl_c.pc_source = PCSRC_ALU;
                if (ctl.mem_ready) begin
                    ctrl_c.ir_write = 1'b1;
                    ctrl_c.pc_write = 1'b1;
                    state_d         = ST_DECODE;
                end else if (wait_limit_c) begin
                    state_d   = ST_HALT;
                    bus_err_d = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                end
            end
            ST_DECODE: begin
                ctrl_c.alu_src_b = SRCB_IMM_SH;
                ctrl_c.alu_ctrl  = ALU_ADD;
                case (ctl.opcode)
                    OP_RTYPE:     state_d = ST_EXEC_R;
                    OP_LW, OP_SW: state_d = ST_MEM_ADDR;
                    OP_BEQ:       state_d = ST_BRANCH;
                    OP_J:         state_d = ST_JUMP;
                    OP_ADDI:      state_d = ST_ADDI_EX;
                    default: begin
                        state_d   = ST_HALT;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            ST_EXEC_R: begin
                ctrl_c.alu_src_a = 1'b1;
                ctrl_c.alu_src_b = SRCB_B;
                ctrl_c.alu_ctrl  = dec_alu_ctrl;
                if (dec_valid) begin
                    state_d = ST_R_WB;
                end else begin
                    state_d   = ST_HALT;
                    illegal_d = 1'b1;
                end
            end
            ST_R_WB: begin
                ctrl_c.reg_dst   = 1'b1;
                ctrl_c.reg_write = 1'b1;
                ctrl_c.retire    = 1'b1;
                state_d          = ST_FETCH;
            end
            ST_MEM_ADDR: begin
                ctrl_c.alu_src_a = 1'b1;
                ctrl_c.alu_src_b = SRCB_IMM;
                ctrl_c.alu_ctrl  = ALU_ADD;
                state_d = (ctl.opcode == OP_SW) ? ST_MEM_WR : ST_MEM_RD;
            end
            ST_MEM_RD: begin
                ctrl_c.mem_read = 1'b1;
                ctrl_c.i_or_d   = 1'b1;
                if (ctl.mem_ready) begin
                    state_d = ST_MEM_WB;
                end else if (wait_limit_c) begin
                    state_d   = ST_HALT;
                    bus_err_d = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                end
            end
            ST_MEM_WB: begin
                ctrl_c.mem_to_reg = 1'b1;
                ctrl_c.reg_write  = 1'b1;
                ctrl_c.retire     = 1'b1;
                state_d           = ST_FETCH;
            end
            ST_MEM_WR: begin
                ctrl_c.mem_write = 1'b1;
                ctrl_c.i_or_d    = 1'b1;
                if (ctl.mem_ready) begin
                    ctrl_c.retire = 1'b1;
                    state_d       = ST_FETCH;
                end else if (wait_limit_c) begin
                    state_d   = ST_HALT;
                    bus_err_d = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                end
            end
            ST_BRANCH: begin
                ctrl_c.alu_src_a     = 1'b1;
                ctrl_c.alu_src_b     = SRCB_B;
                ctrl_c.alu_ctrl      = ALU_SUB;
                ctrl_c.pc_write_cond = 1'b1;
                ctrl_c.pc_source     = PCSRC_ALUOUT;
                ctrl_c.retire        = 1'b1;
                state_d              = ST_FETCH;
            end
            ST_JUMP: begin
                ctrl_c.pc_write  = 1'b1;
                ctrl_c.pc_source = PCSRC_JUMP;
                ctrl_c.retire    = 1'b1;
                state_d          = ST_FETCH;
            end
            ST_ADDI_EX: begin
                ctrl_c.alu_src_a = 1'b1;
                ctrl_c.alu_src_b = SRCB_IMM;
                ctrl_c.alu_ctrl  = ALU_ADD;
                state_d          = ST_ADDI_WB;
            end
            ST_ADDI_WB: begin
                ctrl_c.reg_write = 1'b1;
                ctrl_c.retire    = 1'b1;
                state_d          = ST_FETCH;
            end
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_IDLE;
        endcase

        // Strobes drop in the same cycle reset is asserted so no access or retire completes.
        if (!reset_n) begin
            ctrl_c = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            wait_cnt_q <= '0;
            illegal_q  <= 1'b0;
            bus_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            illegal_q  <= illegal_d;
            bus_err_q  <= bus_err_d;
        end
    end

    assign ctl.pc_write      = ctrl_c.pc_write;
    assign ctl.pc_write_cond = ctrl_c.pc_write_cond;
    assign ctl.i_or_d        = ctrl_c.i_or_d;
    assign ctl.mem_read      = ctrl_c.mem_read;
    assign ctl.mem_write     = ctrl_c.mem_write;
    assign ctl.ir_write      = ctrl_c.ir_write;
    assign ctl.reg_dst       = ctrl_c.reg_dst;
    assign ctl.mem_to_reg    = ctrl_c.mem_to_reg;
    assign ctl.reg_write     = ctrl_c.reg_write;
    assign ctl.alu_src_a     = ctrl_c.alu_src_a;
    assign ctl.alu_src_b     = ctrl_c.alu_src_b;
    assign ctl.alu_ctrl      = ctrl_c.alu_ctrl;
    assign ctl.pc_source     = ctrl_c.pc_source;
    assign ctl.retire        = ctrl_c.retire;
    assign ctl.illegal_op    = illegal_q;
    assign ctl.bus_error     = bus_err_q;
    assign ctl.state         = state_q;

endmodule

// File: doc/mips_multicycle_ctrl.md
Name: mips_multicycle_ctrl

Overview:
Main control FSM for the multicycle MIPS datapath: PC, register file, IR, ALUOut, shared instruction/data memory.
Sequences each instruction through fetch, decode, execute, memory and writeback. Drives all datapath enables and mux selects.
Handles memory wait states (mem_ready), memory timeout, and illegal opcodes.
Sits between the IR opcode/funct fields and the datapath.

Parameters:
MEM_TIMEOUT, 16, max cycles a memory access may wait for mem_ready before a bus error (range 1..255)
ENABLE_SLT, 1, 1 = decode funct 42 (slt); 0 = treat slt as illegal

Ports:
clock  input  1  rising-edge system clock
reset_n  input  1  synchronous active-low reset
opcode  input  6  IR[31:26]
funct  input  6  IR[5:0]
zero  input  1  ALU zero flag (beq)
mem_ready  input  1  memory completes the current access this cycle
pc_write  output  1  unconditional PC load
pc_write_cond  output  1  PC load if zero
i_or_d  output  1  0 = memory address from PC, 1 = from ALUOut
mem_read  output  1  memory read strobe
mem_write  output  1  memory write strobe
ir_write  output  1  IR load
reg_dst  output  1  1 = rd, 0 = rt
mem_to_reg  output  1  1 = MDR to regfile, 0 = ALUOut
reg_write  output  1  regfile write enable
alu_src_a  output  1  0 = PC, 1 = A
alu_src_b  output  2  0 = B, 1 = const 4, 2 = sign-ext imm, 3 = sign-ext imm<<2
alu_ctrl  output  4  0000 and, 0001 or, 0010 add, 0110 sub, 0111 slt
pc_source  output  2  0 = ALU result, 1 = ALUOut, 2 = jump target
retire  output  1  one-cycle pulse when an instruction completes
illegal_op  output  1  sticky, set on undecodable opcode/funct
bus_error  output  1  sticky, set on memory timeout
state  output  4  current state, for debug

Behaviour:
- Clocking: one clock (clock); reset_n synchronous, active-low.
- Reset: state=IDLE; illegal_op=0; bus_error=0; wait counter=0. Unlisted outputs are 0 in every state, and retire=0.
- State encoding: IDLE=0, FETCH=1, DECODE=2, MEM_ADDR=3, MEM_RD=4, MEM_WB=5, MEM_WR=6, EXEC_R=7, R_WB=8, BRANCH=9, JUMP=10, ADDI_EX=11, ADDI_WB=12, HALT=15.
- IDLE: all outputs 0. Goes to FETCH next cycle.
- FETCH: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=1, alu_ctrl=add, pc_source=0.
  - ir_write and pc_write assert only in the cycle mem_ready=1 (Mealy), then go to DECODE.
  - Otherwise stay in FETCH and increment the wait counter.
- DECODE: alu_src_a=0, alu_src_b=3, alu_ctrl=add (branch target into ALUOut). Next state by opcode:
  - 0 → EXEC_R
  - 35 (lw) or 43 (sw) → MEM_ADDR
  - 4 (beq) → BRANCH
  - 2 (j) → JUMP
  - 8 (addi) → ADDI_EX
  - other → HALT, set illegal_op
- EXEC_R: alu_src_a=1, alu_src_b=0. alu_ctrl from funct:
  - 32 → add, 34 → sub, 36 → and, 37 → or, 42 → slt (only if ENABLE_SLT).
  - Other funct → HALT, set illegal_op, no writeback.
  - Valid funct → R_WB.
- R_WB: reg_dst=1, mem_to_reg=0, reg_write=1, retire=1. Next FETCH.
- MEM_ADDR: alu_src_a=1, alu_src_b=2, alu_ctrl=add. Next MEM_RD (lw) or MEM_WR (sw).
- MEM_RD: mem_read=1, i_or_d=1. On mem_ready go to MEM_WB.
- MEM_WB: reg_dst=0, mem_to_reg=1, reg_write=1, retire=1. Next FETCH.
- MEM_WR: mem_write=1, i_or_d=1. On mem_ready: retire=1, go to FETCH.
- BRANCH: alu_src_a=1, alu_src_b=0, alu_ctrl=sub, pc_write_cond=1, pc_source=1, retire=1. Next FETCH.
- JUMP: pc_write=1, pc_source=2, retire=1. Next FETCH.
- ADDI_EX: alu_src_a=1, alu_src_b=2, alu_ctrl=add. Next ADDI_WB.
- ADDI_WB: reg_dst=0, mem_to_reg=0, reg_write=1, retire=1. Next FETCH.
- Wait counter (8 bit):
  - Cleared on entry to FETCH, MEM_RD and MEM_WR, and whenever mem_ready=1.
  - Increments on each cycle in those states with mem_ready=0.
  - When it reaches MEM_TIMEOUT with mem_ready still 0: go to HALT, set bus_error, drop all strobes.
  - mem_ready=1 in the same cycle the limit is reached counts as success.
- HALT: all outputs 0. Left only by reset_n=0.
- mem_ready outside FETCH/MEM_RD/MEM_WR is ignored.
- Reset asserted mid-access: next cycle is IDLE, strobes drop immediately, no write completes, no retire.

Decomposition:
- Shared package mips_pkg: opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI), funct constants, ALU control codes, state encoding.
- One sub-module: mips_alu_decode, combinational funct → alu_ctrl plus a valid flag. It is reusable by a later pipelined control unit.

Test Plan:
- Reset, then fetch add (opcode 0, funct 32) with mem_ready tied 1 → states 0,1,2,7,8,1; alu_ctrl=0010 in EXEC_R; reg_write=1 and retire=1 in R_WB; 4 cycles from FETCH to next FETCH.
- lw with mem_ready delayed 3 cycles in MEM_RD → mem_read held 4 cycles with i_or_d=1; MEM_WB has mem_to_reg=1, reg_write=1; exactly one retire.
- beq with zero=1, then beq with zero=0 → pc_write_cond=1, pc_source=1 in BRANCH both times; retire pulses once per instruction.
- Opcode 63, then (after reset) R-type funct 0 → HALT (15), illegal_op=1, reg_write never asserted; reset clears both.
- MEM_TIMEOUT=4, sw with mem_ready=0 → mem_write high 4 cycles, then HALT, bus_error=1, mem_write=0. Repeat with mem_ready=1 on the 4th cycle → normal retire.
- reset_n low during MEM_WR wait → state=0 next cycle, mem_write=0, no retire; resumes at FETCH one cycle after release.
